// File: rtl/piso_serializer.sv
// MSB-first parallel-in/serial-out serializer with a valid/ready load handshake and a shift_en stall.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  // sout_q holds the bit on the wire; shreg_q holds the bits still to go, next one at the top.
  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             sout_q, sout_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             last_cycle;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

`ifdef PISO_PARITY_EN
  assign last_cycle = (state_q == PARITY);
`else
  assign last_cycle = (state_q == SHIFT) && (cnt_q == LAST_IDX);
`endif

  assign load_ready = (state_q == IDLE) || (last_cycle && shift_en);
  assign accept     = load_valid && load_ready;
  assign cnt_inc    = cnt_q + 1'b1;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the branches leaves it unassigned (no latch).
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    sout_d   = sout_q;
    valid_d  = valid_q;
    done_d   = done_q;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif

    if (accept) begin
      state_d  = SHIFT;
      shreg_d  = load_data[WIDTH-2:0];
      cnt_d    = '0;
      sout_d   = load_data[WIDTH-1];
      valid_d  = 1'b1;
      done_d   = 1'b0;
`ifdef PISO_PARITY_EN
      parity_d = ^load_data;
`endif
    end else if (shift_en) begin
      case (state_q)
        SHIFT: begin
          if (cnt_q == LAST_IDX) begin
`ifdef PISO_PARITY_EN
            state_d = PARITY;
            sout_d  = parity_q;
            done_d  = 1'b1;
`else
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
            sout_d  = 1'b0;
            valid_d = 1'b0;
            done_d  = 1'b0;
`endif
          end else begin
            cnt_d   = cnt_inc;
            shreg_d = shreg_q << 1;
            sout_d  = shreg_q[WIDTH-2];
`ifdef PISO_PARITY_EN
            done_d  = 1'b0;
`else
            done_d  = (cnt_inc == LAST_IDX);
`endif
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          state_d = IDLE;
          shreg_d = '0;
          cnt_d   = '0;
          sout_d  = 1'b0;
          valid_d = 1'b0;
          done_d  = 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      sout_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      sout_q   <= sout_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign sout       = sout_q;
  assign sout_valid = valid_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: stimulus queues expected serial bits, a negedge monitor checks them.
module tb_piso_serializer;

  localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             sout;
  logic             sout_valid;
  logic             frame_done;

  piso_serializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_data  (load_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .shift_en   (shift_en),
    .sout       (sout),
    .sout_valid (sout_valid),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // Expected frame: data MSB first, then the even-parity bit when configured.
  task automatic push_frame(input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) begin
`ifdef PISO_PARITY_EN
      exp_q.push_back('{b: w[i], done: 1'b0});
`else
      exp_q.push_back('{b: w[i], done: (i == 0)});
`endif
    end
`ifdef PISO_PARITY_EN
    exp_q.push_back('{b: ^w, done: 1'b1});
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns one cycle after the accepting edge, with the first bit on sout.
  task automatic send(input logic [WIDTH-1:0] w);
    bit ok;
    ok = 1'b0;
    load_data  = w;
    load_valid = 1'b1;
    #1;
    for (int t = 0; t < 64; t++) begin
      if (load_ready) begin
        push_frame(w);
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) check("send_ready_timeout", load_ready, 1);
    step();
    load_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int t = 0; t < 64; t++) begin
      if (!sout_valid) return;
      n++;
      step();
    end
  endtask

  // Monitor: a held bit (shift_en=0) is checked but stays at the head of the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (sout_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_bit", sout_valid, 0);
          end else begin
            check("sout", sout, exp_q[0].b);
            check("frame_done", frame_done, exp_q[0].done);
            if (shift_en) void'(exp_q.pop_front());
          end
        end else begin
          check("idle_sout", sout, 0);
          check("idle_frame_done", frame_done, 0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    bit b2b_seen;

    reset      = 1'b1;
    load_data  = '0;
    load_valid = 1'b0;
    shift_en   = 1'b1;
    step();
    step();
    check("rst_sout", sout, 0);
    check("rst_valid", sout_valid, 0);
    check("rst_done", frame_done, 0);
    check("rst_ready", load_ready, 1);
    reset = 1'b0;
    step();

    // Basic frame: 8'hB4 -> 1,0,1,1,0,1,0,0.
    send(8'hB4);
    check("basic_bit1", sout, 1);
    wait_idle(n);
    check("basic_len", n, FRAME_LEN);
    check("basic_idle_ready", load_ready, 1);
    check("basic_drained", exp_q.size(), 0);

    // Stall for 3 cycles while bit 2 (a 0) is on the wire.
    send(8'hB4);
    step();
    shift_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_hold_sout", sout, 0);
      check("stall_hold_valid", sout_valid, 1);
      step();
    end
    shift_en = 1'b1;
    wait_idle(n);
    check("stall_len", 4 + n, FRAME_LEN + 3);
    check("stall_drained", exp_q.size(), 0);

    // Back-to-back: 8'hFF held valid is accepted in the final cycle of 8'hB4.
    load_data  = 8'hB4;
    load_valid = 1'b1;
    #1;
    check("b2b_first_ready", load_ready, 1);
    push_frame(8'hB4);
    step();
    load_data = 8'hFF;
    b2b_seen  = 1'b0;
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      check("b2b_continuous_valid", sout_valid, 1);
      if (load_valid && load_ready) begin
        check("b2b_accept_cycle", i, FRAME_LEN - 1);
        push_frame(8'hFF);
        b2b_seen = 1'b1;
        step();
        load_valid = 1'b0;
      end else begin
        step();
      end
    end
    check("b2b_accepted", b2b_seen, 1);
    check("b2b_end_idle", sout_valid, 0);
    check("b2b_drained", exp_q.size(), 0);

    // Load presented mid-frame (during bit 3) is ignored.
    send(8'hB4);
    step();
    step();
    load_data  = 8'h00;
    load_valid = 1'b1;
    #1;
    check("ignored_ready_low", load_ready, 0);
    step();
    load_valid = 1'b0;
    wait_idle(n);
    check("ignored_len", 3 + n, FRAME_LEN);
    for (int i = 0; i < 3; i++) step();
    check("ignored_no_extra", sout_valid, 0);
    check("ignored_drained", exp_q.size(), 0);

    // 8'hA7 -> 1,0,1,0,0,1,1,1 (+ parity 1 when configured).
    send(8'hA7);
    check("a7_bit1", sout, 1);
    wait_idle(n);
    check("a7_len", n, FRAME_LEN);
    check("a7_drained", exp_q.size(), 0);

    // Asynchronous reset between edges during bit 4 (a 1) of 8'hB4.
    send(8'hB4);
    for (int i = 0; i < 3; i++) step();
    check("pre_reset_bit4", sout, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_sout", sout, 0);
    check("async_rst_valid", sout_valid, 0);
    check("async_rst_done", frame_done, 0);
    check("async_rst_ready", load_ready, 1);
    exp_q.delete();
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("post_rst_silent", sout_valid, 0);
      step();
    end
    check("post_rst_ready", load_ready, 1);

    // A fresh frame after reset is serialized normally.
    send(8'h5A);
    wait_idle(n);
    check("post_rst_len", n, FRAME_LEN);
    step();
    check("final_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
